// File: rtl/mux_2_s.sv
// mux_2_s -- 4-to-1 word selector with a registered output stage.
//
// Picks one of four w-bit words with a 2-bit select and presents the result
// one clock later, together with the select that produced it, a valid flag
// and a one-cycle change-detect pulse.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   en       in   1   capture enable
//   d0..d3   in   w   candidate data words (s = 00..11)
//   s        in   2   select
//   o        out  w   registered selected word
//   o_valid  out  1   o holds a word captured since the last reset
//   s_q      out  2   select value that produced the current o
//   o_chg    out  1   last capture changed o (or was the first one)
module mux_2_s #(
  parameter int w = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [w-1:0] d0,
  input  logic [w-1:0] d1,
  input  logic [w-1:0] d2,
  input  logic [w-1:0] d3,
  input  logic [1:0]   s,
  output logic [w-1:0] o,
  output logic         o_valid,
  output logic [1:0]   s_q,
  output logic         o_chg
);

  logic [w-1:0] sel;

  logic [w-1:0] o_q,     o_d;
  logic [1:0]   src_q,   src_d;
  logic         valid_q, valid_d;
  logic         chg_q,   chg_d;

  // Every select code maps to a word, so there is no default/X arm.
  always_comb begin
    unique case (s)
      2'b00: sel = d0;
      2'b01: sel = d1;
      2'b10: sel = d2;
      2'b11: sel = d3;
    endcase
  end

  // Only the enable gates the datapath; with en low the data and select
  // inputs are never looked at, so undefined values there cannot leak out.
  always_comb begin
    o_d     = o_q;
    src_d   = src_q;
    valid_d = valid_q;
    chg_d   = 1'b0;
    if (en) begin
      o_d     = sel;
      src_d   = s;
      valid_d = 1'b1;
      // The first capture after reset always counts as a change, even when
      // the captured word equals the reset value of zero.
      chg_d   = (sel != o_q) || !valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= '0;
      src_q   <= 2'b00;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      o_q     <= o_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
    end
  end

  assign o       = o_q;
  assign s_q     = src_q;
  assign o_valid = valid_q;
  assign o_chg   = chg_q;

endmodule

// File: tb/tb_mux_2_s.sv
// tb_mux_2_s -- scoreboard bench for mux_2_s (w = 4).
//
// A driver applies one vector per cycle on the falling edge and pushes the
// expected registered response into a queue; a monitor pops and compares
// shortly after each rising edge. Reset behaviour is checked directly since
// it does not wait for a clock edge.
module tb_mux_2_s;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] o;
    logic [1:0]   sq;
    logic         v;
    logic         chg;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] d0, d1, d2, d3;
  logic [1:0]   s;
  logic [W-1:0] o;
  logic         o_valid;
  logic [1:0]   s_q;
  logic         o_chg;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference state for the random sweep.
  logic [W-1:0] m_o;
  logic         m_v;

  mux_2_s #(.w(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .s       (s),
    .o       (o),
    .o_valid (o_valid),
    .s_q     (s_q),
    .o_chg   (o_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_o"},       32'(o),       32'h0);
    check({tag, "_s_q"},     32'(s_q),     32'h0);
    check({tag, "_o_valid"}, 32'(o_valid), 32'h0);
    check({tag, "_o_chg"},   32'(o_chg),   32'h0);
    $display("reset %s: o=%0h s_q=%0d o_valid=%0b o_chg=%0b", tag, o, s_q, o_valid, o_chg);
  endtask

  // Apply one vector and queue the response expected one edge later.
  task automatic issue(input logic e, input logic [1:0] sv,
                       input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic [W-1:0] a2, input logic [W-1:0] a3,
                       input logic [W-1:0] eo, input logic [1:0] esq,
                       input logic ev, input logic echg);
    exp_t x;
    @(negedge clk);
    en = e; s = sv; d0 = a0; d1 = a1; d2 = a2; d3 = a3;
    x.o = eo; x.sq = esq; x.v = ev; x.chg = echg;
    exp_q.push_back(x);
  endtask

  // Wait (bounded) until the monitor has consumed every queued response.
  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #3;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: compare each queued response after the edge that produced it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        txn++;
        check("o",       32'(o),       32'(x.o));
        check("s_q",     32'(s_q),     32'(x.sq));
        check("o_valid", 32'(o_valid), 32'(x.v));
        check("o_chg",   32'(o_chg),   32'(x.chg));
        $display("txn %0d: o=%0h s_q=%0d o_valid=%0b o_chg=%0b | exp o=%0h s_q=%0d v=%0b chg=%0b",
                 txn, o, s_q, o_valid, o_chg, x.o, x.sq, x.v, x.chg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   rs;
    logic [W-1:0] r0, r1, r2, r3, rsel;
    logic         rchg;

    // Reset with arbitrary inputs: outputs clear without a clock edge.
    rst_n = 1'b1; en = 1'b1; s = 2'b10;
    d0 = 4'h3; d1 = 4'h9; d2 = 4'h6; d3 = 4'hE;
    #3 rst_n = 1'b0;
    #1 check_reset("async_assert");
    #2 check_reset("held_over_edge");
    en = 1'b0;
    #2 rst_n = 1'b1;

    // First capture after reset: zero word still flags a change.
    issue(1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1);
    issue(1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0);

    // Exhaustive select, back-to-back changing captures.
    issue(1'b1, 2'b00, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 2'b00, 1'b1, 1'b1);
    issue(1'b1, 2'b01, 4'h1, 4'h2, 4'h4, 4'h8, 4'h2, 2'b01, 1'b1, 1'b1);
    issue(1'b1, 2'b10, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 2'b10, 1'b1, 1'b1);
    issue(1'b1, 2'b11, 4'h1, 4'h2, 4'h4, 4'h8, 4'h8, 2'b11, 1'b1, 1'b1);

    // Hold: en low, select and d3 change, outputs stay put.
    issue(1'b0, 2'b00, 4'h1, 4'h2, 4'h4, 4'hF, 4'h8, 2'b11, 1'b1, 1'b0);
    issue(1'b0, 2'b00, 4'h1, 4'h2, 4'h4, 4'hF, 4'h8, 2'b11, 1'b1, 1'b0);

    // Change detect: 5, 5 from another input, then A.
    issue(1'b1, 2'b00, 4'h5, 4'h0, 4'h0, 4'h0, 4'h5, 2'b00, 1'b1, 1'b1);
    issue(1'b1, 2'b01, 4'h0, 4'h5, 4'h0, 4'h0, 4'h5, 2'b01, 1'b1, 1'b0);
    issue(1'b1, 2'b10, 4'h0, 4'h5, 4'hA, 4'h0, 4'hA, 2'b10, 1'b1, 1'b1);

    // Capture C, then reset between edges.
    issue(1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 4'hC, 4'hC, 2'b11, 1'b1, 1'b1);
    drain();
    en = 1'b0;
    rst_n = 1'b0;
    #1 check_reset("mid_op");
    rst_n = 1'b1;

    // Random sweep with en held high.
    m_o = '0;
    m_v = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rs = 2'($urandom_range(0, 3));
      r0 = 4'($urandom); r1 = 4'($urandom);
      r2 = 4'($urandom); r3 = 4'($urandom);
      case (rs)
        2'b00:   rsel = r0;
        2'b01:   rsel = r1;
        2'b10:   rsel = r2;
        default: rsel = r3;
      endcase
      rchg = (rsel != m_o) || !m_v;
      m_o  = rsel;
      m_v  = 1'b1;
      issue(1'b1, rs, r0, r1, r2, r3, rsel, rs, 1'b1, rchg);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_2_s.md
# mux_2_s

Parameterized 4-to-1 selector with a registered output stage. It selects one of four w-bit data words using a 2-bit select and presents the result one clock later, with a valid flag and a change-detect pulse. It is a datapath leaf block, used wherever a registered word selection is needed between pipeline stages.

## Interface
Parameters:
- w, 4: data width in bits (w >= 1).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  capture enable; when 1, the selected word is registered this cycle.
- d0  input  w  data word selected when s = 2'b00.
- d1  input  w  data word selected when s = 2'b01.
- d2  input  w  data word selected when s = 2'b10.
- d3  input  w  data word selected when s = 2'b11.
- s  input  2  select.
- o  output  w  registered selected word.
- o_valid  output  1  1 when o holds a word captured since the last reset.
- s_q  output  2  select value that produced the current o.
- o_chg  output  1  one-cycle pulse; 1 when the last capture changed the value of o.

## Operation
- The combinational select is sel = d[s]: 00->d0, 01->d1, 10->d2, 11->d3. Every 2-bit code is valid and there is no default or X case.
- On a rising edge with en = 1:
  - o <= sel
  - s_q <= s
  - o_valid <= 1
  - o_chg <= (sel != o) or (o_valid == 0)
- On a rising edge with en = 0:
  - o, s_q and o_valid hold their values.
  - o_chg <= 0.
- Width rule: every data path is exactly w bits, with no extension or truncation. Select inputs wider than 2 bits are not supported; the port is exactly 2 bits.
- Inputs that are X or Z while en = 0 have no effect on any output.

## Timing
- Latency: 1 clock from d*/s/en being sampled to o/s_q being updated.
- Throughput: one new selection per cycle when en is held at 1.
- Reset values, applied asynchronously while rst_n = 0:
  - o = 0
  - s_q = 2'b00
  - o_valid = 0
  - o_chg = 0
- Reset release: the first rising edge with rst_n = 1 and en = 1 performs a normal capture. Its o_chg is 1 even when sel = 0, because o_valid was 0.
- Reset asserted mid-operation clears every output immediately, without waiting for a clock edge. Any capture in progress is discarded.
- Simultaneous changes of s and d* in the same cycle: only the values sampled at the rising edge matter.
- o_chg is high for exactly one cycle per qualifying capture. Back-to-back changing captures keep it high on consecutive cycles.

## Test plan
1. Reset: assert rst_n = 0 with arbitrary inputs -> o = 0, s_q = 00, o_valid = 0, o_chg = 0 immediately, without a clock edge.
2. Exhaustive select, w = 4, en = 1: d0 = 4'h1, d1 = 4'h2, d2 = 4'h4, d3 = 4'h8; step s through 00, 01, 10, 11 -> one cycle later o = 1, 2, 4, 8 respectively and s_q matches s.
3. Hold: capture o = 4'h8, then set en = 0 and change s to 00 and d3 to 4'hF -> o stays 8, s_q stays 11, o_chg = 0.
4. Change detect: with en = 1, capture 4'h5, then capture 4'h5 again from a different input, then capture 4'hA -> o_chg = 1, 0, 1 on the three result cycles.
5. First capture after reset: release rst_n, all d* = 0, s = 00, en = 1 -> o = 0, o_valid = 1, o_chg = 1 for one cycle.
6. Mid-operation reset and random sweep:
   - Pulse rst_n low between clock edges while o = 4'hC -> all outputs return to reset values at once.
   - Then run 64 random (s, d0..d3) vectors with en = 1 -> o equals d[s] of the previous cycle on every cycle.
